// File: rtl/fft_peak_detect.sv
// Per-frame peak search over FFT output bins: tracks the largest-magnitude bin,
// the summed magnitude and the bin count, then holds the result until consumed.
module fft_peak_detect #(
    parameter int N_BINS  = 64,
    parameter bit SKIP_DC = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [7:0] in_re,
    input  logic signed [7:0] in_im,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        peak_bin,
    output logic [7:0]        peak_mag,
    output logic [13:0]       frame_energy,
    output logic [6:0]        frame_len
);

    localparam int DATA_W = 8;
    localparam logic [5:0] LAST_IDX = 6'(N_BINS - 1);

    typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} state_t;

    state_t state, state_nxt;

    logic       accept;
    logic       last_bin;
    logic       result_taken;
    logic [5:0] idx;

    logic       vld_p1;
    logic [7:0] abs_re_p1;
    logic [7:0] abs_im_p1;
    logic [5:0] idx_p1;
    logic [7:0] mag_p1;
    logic       peak_upd_p1;

    // |-128| must come out as 128, so the result is read back as unsigned
    function automatic logic [7:0] abs_fn(input logic signed [DATA_W-1:0] x);
        return x[DATA_W-1] ? 8'(-x) : 8'(x);
    endfunction

    function automatic logic [7:0] mag_fn(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = (a >= b) ? a : b;
        lo = (a >= b) ? b : a;
        return hi + (lo >> 1);
    endfunction

    assign accept       = in_valid && in_ready;
    assign last_bin     = in_last || (idx == LAST_IDX);
    assign result_taken = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && last_bin) state_nxt = FLUSH;
            FLUSH:   state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
            if (accept) idx <= last_bin ? 6'd0 : idx + 6'd1;
        end
    end

    // Stage 1: register absolute values and bin index of the accepted bin
    always_ff @(posedge clk) begin
        if (accept) begin
            abs_re_p1 <= abs_fn(in_re);
            abs_im_p1 <= abs_fn(in_im);
            idx_p1    <= idx;
        end
    end

    // Stage 2: magnitude, energy accumulation and strict-greater peak update
    assign mag_p1      = mag_fn(abs_re_p1, abs_im_p1);
    assign peak_upd_p1 = vld_p1 && !(SKIP_DC && (idx_p1 == 6'd0)) && (mag_p1 > peak_mag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_bin     <= '0;
            peak_mag     <= '0;
            frame_energy <= '0;
            frame_len    <= '0;
        end else if (result_taken) begin
            peak_bin     <= '0;
            peak_mag     <= '0;
            frame_energy <= '0;
            frame_len    <= '0;
        end else if (vld_p1) begin
            frame_energy <= frame_energy + 14'(mag_p1);
            frame_len    <= frame_len + 7'd1;
            if (peak_upd_p1) begin
                peak_bin <= idx_p1;
                peak_mag <= mag_p1;
            end
        end
    end

endmodule

// File: doc/fft_peak_detect.md
FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 Parameter: N_BINS, default 64, maximum bins per frame; power of two, 2..64.
REQ-002 Parameter: SKIP_DC, default 1; when 1, bin 0 is excluded from the peak search.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  upstream FFT output bin present.
REQ-006 Port: in_ready  output  1  block accepts a bin this cycle.
REQ-007 Port: in_re  input  8  bin real part, signed two's complement.
REQ-008 Port: in_im  input  8  bin imaginary part, signed two's complement.
REQ-009 Port: in_last  input  1  final bin of frame; qualified by in_valid.
REQ-010 Port: out_valid  output  1  frame result available.
REQ-011 Port: out_ready  input  1  downstream consumes result.
REQ-012 Port: peak_bin  output  6  index of the largest-magnitude bin.
REQ-013 Port: peak_mag  output  8  magnitude of the peak bin, unsigned.
REQ-014 Port: frame_energy  output  14  sum of all bin magnitudes in the frame, unsigned.
REQ-015 Port: frame_len  output  7  number of bins accepted in the frame, 1..64.

Function
REQ-016 A bin SHALL be accepted only on a cycle where in_valid and in_ready are both high.
REQ-017 Bin index SHALL be a 6-bit counter: 0 for the first accepted bin of a frame, +1 per accepted bin.
REQ-018 Magnitude SHALL be max(|re|,|im|) + floor(min(|re|,|im|)/2); |-128| = 128; range 0..192; no saturation needed.
REQ-019 The FSM SHALL have three states: ACCUM (in_ready=1), FLUSH (in_ready=0), HOLD (in_ready=0, out_valid=1).
REQ-020 ACCUM->FLUSH SHALL occur on acceptance of a bin with in_last=1, or of bin index N_BINS-1, whichever comes first; the index counter then returns to 0.
REQ-021 FLUSH->HOLD SHALL be unconditional after 1 cycle.
REQ-022 HOLD->ACCUM SHALL occur on the cycle out_valid && out_ready.
REQ-023 Pipeline, stage 1: on acceptance, register |re|, |im| and the bin index.
REQ-024 Pipeline, stage 2 (next cycle): compute the magnitude, add it to energy, and update the peak.
REQ-025 out_valid SHALL rise exactly 2 cycles after the final bin handshake.
REQ-026 Peak SHALL update only when mag > current peak_mag (strict), so on ties the lowest index wins.
REQ-027 Peak search SHALL start each frame with peak_mag=0, peak_bin=0; an all-zero frame yields peak_bin=0, peak_mag=0.
REQ-028 SKIP_DC=1: bin 0 SHALL NOT update the peak, but SHALL still contribute to frame_energy.
REQ-029 peak_bin, peak_mag, frame_energy and frame_len SHALL remain stable while out_valid=1.
REQ-030 Accumulators SHALL clear on the HOLD->ACCUM handshake; a bin offered in that same cycle SHALL NOT be accepted, since in_ready is still 0.
REQ-031 in_last asserted with in_valid=0 SHALL be ignored.
REQ-032 frame_energy SHALL be 14 bits wide; the maximum 64*192=12288 does not overflow.

Reset
REQ-033 rst_n low SHALL asynchronously force state ACCUM, index 0, all pipeline valids 0, and out_valid=0.
REQ-034 rst_n low SHALL asynchronously force peak_bin=0, peak_mag=0, frame_energy=0 and frame_len=0; in_ready=1 on the first cycle after release.
REQ-035 Reset mid-frame or during HOLD SHALL discard the partial or held result; no out_valid pulse follows.

Verification
REQ-036 Single tone: 64 bins all 0 except bin 5 (re=100, im=-40) -> peak_bin=5, peak_mag=120, frame_energy=120, frame_len=64, out_valid 2 cycles after bin 63.
REQ-037 Tie/extremes: bins 3 and 9 both (re=50, im=0), bin 20 (re=-128, im=-128) -> peak_bin=20, peak_mag=192; repeat without bin 20 -> peak_bin=3, peak_mag=50.
REQ-038 DC skip: only bin 0 nonzero (re=127, im=0), SKIP_DC=1 -> peak_bin=0, peak_mag=0, frame_energy=127.
REQ-039 Early last: in_last on bin 10, all bins (re=1, im=1) -> frame_len=11, frame_energy=11, peak_bin=1 with SKIP_DC=1 (mag=1 each); in_ready=0 until handshake.
REQ-040 Backpressure: out_ready held low 20 cycles -> outputs stable, in_ready=0, upstream bins not consumed; the next frame starts cleanly after the handshake.
REQ-041 Reset: assert rst_n at bin 30 -> out_valid never rises; the following full frame reports correct values, unaffected by the aborted frame.
